// File: rtl/fft_bfly_sched.sv
// ---------------------------------------------------------------------------
// fft_bfly_sched
// Schedules a radix-2 butterfly through an in-place N-point DIT FFT. The data
// RAM holds the input in bit-reversed order, and the result ends up in natural
// order in the same RAM. Each stage issues N/2 operand reads, one per cycle.
// The stage then drains until every issued butterfly has been written back, so
// the next stage never reads a location that still has a write pending.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 begin a transform (accepted in IDLE only)
//   busy_o, done_o          in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_*_o    data RAM read (pair p/q) and twiddle ROM read
//   tw_addr_o               twiddle ROM address
//   rd_*_i, tw_*_i          RAM/ROM data, valid RAM_LAT cycles after rd_en_o
//   bf_en_o, bf_*_o         butterfly operands (registered RAM/ROM data)
//   bf_vld_i, bf_y*_i       butterfly results
//   wr_en_o, wr_addr_*_o    dual-port write-back of the butterfly results
//   wr_*_o                  write data (butterfly results passed through)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_ISSUE | one read per cycle, butterfly k of stage s
// ST_DRAIN | reads stopped, waiting for outstanding write-backs
// ST_DONE  | single-cycle done pulse
// ---------------------------------------------------------------------------
module fft_bfly_sched #(
    parameter int N       = 256,
    parameter int LOG2N   = 8,
    parameter int RAM_LAT = 1,
    parameter int BF_LAT  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [LOG2N-1:0]        rd_addr_p_o,
    output logic [LOG2N-1:0]        rd_addr_q_o,
    output logic [LOG2N-2:0]        tw_addr_o,
    input  logic signed [15:0]      rd_p_re_i,
    input  logic signed [15:0]      rd_p_im_i,
    input  logic signed [15:0]      rd_q_re_i,
    input  logic signed [15:0]      rd_q_im_i,
    input  logic signed [15:0]      tw_re_i,
    input  logic signed [15:0]      tw_im_i,
    output logic                    bf_en_o,
    output logic signed [15:0]      bf_xp_re_o,
    output logic signed [15:0]      bf_xp_im_o,
    output logic signed [15:0]      bf_xq_re_o,
    output logic signed [15:0]      bf_xq_im_o,
    output logic signed [15:0]      bf_factor_re_o,
    output logic signed [15:0]      bf_factor_im_o,
    input  logic                    bf_vld_i,
    input  logic signed [15:0]      bf_yp_re_i,
    input  logic signed [15:0]      bf_yp_im_i,
    input  logic signed [15:0]      bf_yq_re_i,
    input  logic signed [15:0]      bf_yq_im_i,
    output logic                    wr_en_o,
    output logic [LOG2N-1:0]        wr_addr_p_o,
    output logic [LOG2N-1:0]        wr_addr_q_o,
    output logic signed [15:0]      wr_p_re_o,
    output logic signed [15:0]      wr_p_im_o,
    output logic signed [15:0]      wr_q_re_o,
    output logic signed [15:0]      wr_q_im_o
);

    localparam int L  = RAM_LAT + 1 + BF_LAT;  // read-to-write latency
    localparam int CW = $clog2(L + 2);         // outstanding count holds L+1
    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            rd_en;
    logic            wr_en;
    logic [LOG2N-1:0] half, j, g, p, q;
    logic [KW-1:0]   tw;

    logic [RAM_LAT-1:0] rd_dly_q;
    logic [L-1:0]       wv_q;
    logic [LOG2N-1:0]   wa_p_q [L];
    logic [LOG2N-1:0]   wa_q_q [L];

    logic               bf_en_q;
    logic signed [15:0] xp_re_q, xp_im_q, xq_re_q, xq_im_q, w_re_q, w_im_q;

    // Butterfly k of stage s: insert a zero bit at position s of k to get p,
    // the partner q sits half a span above, and the twiddle index is j scaled
    // up to the full N/2 twiddle table.
    always_comb begin
        half = LOG2N'(1) << s_q;
        j    = LOG2N'(k_q) & (half - LOG2N'(1));
        g    = LOG2N'(k_q) >> s_q;
        p    = (g << (int'(s_q) + 1)) | j;
        q    = p | half;
        tw   = KW'(j << (LOG2N - 1 - int'(s_q)));
    end

    assign rd_en = (state_q == ST_ISSUE);

    // Only write back results that belong to a read issued since the last
    // reset; anything still inside the butterfly at reset is discarded.
    assign wr_en = bf_vld_i & wv_q[L-1];

    always_comb begin
        cnt_d = cnt_q;
        case ({rd_en, wr_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (k_q == KW'(N/2 - 1)) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle the last write lands so the next stage
                // reads right after it.
                if (cnt_d == '0) begin
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        s_d     = s_q + SW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_dly_q <= '0;
            wv_q     <= '0;
            for (int i = 0; i < L; i++) begin
                wa_p_q[i] <= '0;
                wa_q_q[i] <= '0;
            end
        end else begin
            rd_dly_q[0] <= rd_en;
            for (int i = 1; i < RAM_LAT; i++) begin
                rd_dly_q[i] <= rd_dly_q[i-1];
            end
            wv_q[0]   <= rd_en;
            wa_p_q[0] <= rd_addr_p_o;
            wa_q_q[0] <= rd_addr_q_o;
            for (int i = 1; i < L; i++) begin
                wv_q[i]   <= wv_q[i-1];
                wa_p_q[i] <= wa_p_q[i-1];
                wa_q_q[i] <= wa_q_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bf_en_q <= 1'b0;
            xp_re_q <= '0;
            xp_im_q <= '0;
            xq_re_q <= '0;
            xq_im_q <= '0;
            w_re_q  <= '0;
            w_im_q  <= '0;
        end else begin
            bf_en_q <= rd_dly_q[RAM_LAT-1];
            if (rd_dly_q[RAM_LAT-1]) begin
                xp_re_q <= rd_p_re_i;
                xp_im_q <= rd_p_im_i;
                xq_re_q <= rd_q_re_i;
                xq_im_q <= rd_q_im_i;
                w_re_q  <= tw_re_i;
                w_im_q  <= tw_im_i;
            end
        end
    end

    assign busy_o         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done_o         = (state_q == ST_DONE);
    assign rd_en_o        = rd_en;
    assign rd_addr_p_o    = rd_en ? p  : '0;
    assign rd_addr_q_o    = rd_en ? q  : '0;
    assign tw_addr_o      = rd_en ? tw : '0;

    assign bf_en_o        = bf_en_q;
    assign bf_xp_re_o     = xp_re_q;
    assign bf_xp_im_o     = xp_im_q;
    assign bf_xq_re_o     = xq_re_q;
    assign bf_xq_im_o     = xq_im_q;
    assign bf_factor_re_o = w_re_q;
    assign bf_factor_im_o = w_im_q;

    assign wr_en_o        = wr_en;
    assign wr_addr_p_o    = wr_en ? wa_p_q[L-1] : '0;
    assign wr_addr_q_o    = wr_en ? wa_q_q[L-1] : '0;
    assign wr_p_re_o      = wr_en ? bf_yp_re_i  : '0;
    assign wr_p_im_o      = wr_en ? bf_yp_im_i  : '0;
    assign wr_q_re_o      = wr_en ? bf_yq_re_i  : '0;
    assign wr_q_im_o      = wr_en ? bf_yq_im_i  : '0;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_bfly_sched
// Drives fft_bfly_sched with a behavioural data RAM, twiddle ROM and 3-cycle
// butterfly. A golden in-place FFT (stage by stage) and the cycle schedule
// (stage s issues at 1+133*s .. 128+133*s, operands at +2, writes at +5) give
// the expected outputs on every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_bfly_sched;

    localparam int N      = 256;
    localparam int LOG2N  = 8;
    localparam int SP     = N/2 + 5;          // cycles per stage
    localparam int LASTWR = SP * LOG2N;       // 1064
    localparam int DONEC  = LASTWR + 1;       // 1065

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, rd_en, bf_en, wr_en, bf_vld;
    logic [7:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
    logic [6:0] tw_addr;
    logic signed [15:0] rd_p_re, rd_p_im, rd_q_re, rd_q_im, tw_re, tw_im;
    logic signed [15:0] bf_xp_re, bf_xp_im, bf_xq_re, bf_xq_im, bf_factor_re, bf_factor_im;
    logic signed [15:0] bf_yp_re, bf_yp_im, bf_yq_re, bf_yq_im;
    logic signed [15:0] wr_p_re, wr_p_im, wr_q_re, wr_q_im;

    fft_bfly_sched #(.N(N), .LOG2N(LOG2N), .RAM_LAT(1), .BF_LAT(3)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .busy_o(busy), .done_o(done),
        .rd_en_o(rd_en), .rd_addr_p_o(rd_addr_p), .rd_addr_q_o(rd_addr_q), .tw_addr_o(tw_addr),
        .rd_p_re_i(rd_p_re), .rd_p_im_i(rd_p_im), .rd_q_re_i(rd_q_re), .rd_q_im_i(rd_q_im),
        .tw_re_i(tw_re), .tw_im_i(tw_im),
        .bf_en_o(bf_en), .bf_xp_re_o(bf_xp_re), .bf_xp_im_o(bf_xp_im),
        .bf_xq_re_o(bf_xq_re), .bf_xq_im_o(bf_xq_im),
        .bf_factor_re_o(bf_factor_re), .bf_factor_im_o(bf_factor_im),
        .bf_vld_i(bf_vld), .bf_yp_re_i(bf_yp_re), .bf_yp_im_i(bf_yp_im),
        .bf_yq_re_i(bf_yq_re), .bf_yq_im_i(bf_yq_im),
        .wr_en_o(wr_en), .wr_addr_p_o(wr_addr_p), .wr_addr_q_o(wr_addr_q),
        .wr_p_re_o(wr_p_re), .wr_p_im_o(wr_p_im), .wr_q_re_o(wr_q_re), .wr_q_im_o(wr_q_im)
    );

    // ---------------- behavioural environment ----------------
    logic signed [15:0] mem_re [N], mem_im [N];
    logic signed [15:0] ini_re [N], ini_im [N];
    logic signed [15:0] rom_re [N/2], rom_im [N/2];
    logic               ld = 1'b0;
    int                 pcnt = 0;

    // Q2.13 complex butterfly: yp = xp + w*xq, yq = xp - w*xq
    function automatic logic [63:0] bfly(input logic signed [15:0] xpr, xpi, xqr, xqi, wr, wi);
        int tr, ti;
        logic signed [15:0] a, b, c, d;
        tr = (int'(xqr) * int'(wr) - int'(xqi) * int'(wi)) >>> 13;
        ti = (int'(xqr) * int'(wi) + int'(xqi) * int'(wr)) >>> 13;
        a = 16'(int'(xpr) + tr);
        b = 16'(int'(xpi) + ti);
        c = 16'(int'(xpr) - tr);
        d = 16'(int'(xpi) - ti);
        return {a, b, c, d};
    endfunction

    always @(posedge clk) pcnt <= pcnt + 1;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < N; i++) begin
                mem_re[i] <= ini_re[i];
                mem_im[i] <= ini_im[i];
            end
        end else if (wr_en === 1'b1) begin
            mem_re[wr_addr_p] <= wr_p_re;
            mem_im[wr_addr_p] <= wr_p_im;
            mem_re[wr_addr_q] <= wr_q_re;
            mem_im[wr_addr_q] <= wr_q_im;
        end
        if (rd_en === 1'b1) begin
            rd_p_re <= mem_re[rd_addr_p];
            rd_p_im <= mem_im[rd_addr_p];
            rd_q_re <= mem_re[rd_addr_q];
            rd_q_im <= mem_im[rd_addr_q];
            tw_re   <= rom_re[tw_addr];
            tw_im   <= rom_im[tw_addr];
        end
    end

    logic [2:0]  bv = '0;
    logic [63:0] bp [3];
    always @(posedge clk) begin
        bv    <= {bv[1:0], (bf_en === 1'b1)};
        bp[0] <= bfly(bf_xp_re, bf_xp_im, bf_xq_re, bf_xq_im, bf_factor_re, bf_factor_im);
        bp[1] <= bp[0];
        bp[2] <= bp[1];
    end
    assign bf_vld = bv[2];
    assign {bf_yp_re, bf_yp_im, bf_yq_re, bf_yq_im} = bp[2];

    // ---------------- golden model ----------------
    int plist [LOG2N][N/2];
    int qlist [LOG2N][N/2];
    int twlist[LOG2N][N/2];
    logic signed [15:0] g_re [LOG2N+1][N];
    logic signed [15:0] g_im [LOG2N+1][N];

    bit mdl_on  = 1'b0;
    int mdl_t0  = 0;
    bit imp_run = 1'b0;

    // Butterflies of stage s are ordered group by group, j inside a group.
    task automatic build_lists();
        int half, k;
        for (int s = 0; s < LOG2N; s++) begin
            half = 1 << s;
            k = 0;
            for (int grp = 0; grp < (N/2)/half; grp++) begin
                for (int jj = 0; jj < half; jj++) begin
                    plist[s][k]  = grp * 2 * half + jj;
                    qlist[s][k]  = grp * 2 * half + jj + half;
                    twlist[s][k] = jj * ((N/2)/half);
                    k++;
                end
            end
        end
        for (int a = 0; a < N/2; a++) begin
            real ang;
            ang = 2.0 * 3.14159265358979 * a / N;
            rom_re[a] = 16'($rtoi(8192.0 * $cos(ang)));
            rom_im[a] = 16'(-$rtoi(8192.0 * $sin(ang)));
        end
    endtask

    task automatic compute_gold();
        int p, q, t;
        for (int i = 0; i < N; i++) begin
            g_re[0][i] = ini_re[i];
            g_im[0][i] = ini_im[i];
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < N/2; k++) begin
                p = plist[s][k];
                q = qlist[s][k];
                t = twlist[s][k];
                {g_re[s+1][p], g_im[s+1][p], g_re[s+1][q], g_im[s+1][q]} =
                    bfly(g_re[s][p], g_im[s][p], g_re[s][q], g_im[s][q], rom_re[t], rom_im[t]);
            end
        end
    endtask

    function automatic bit issue_at(input int t, output int s, output int k);
        s = 0;
        k = 0;
        if (t < 1) return 1'b0;
        s = (t - 1) / SP;
        k = (t - 1) % SP;
        return (s < LOG2N) && (k < N/2);
    endfunction

    // ---------------- compare process ----------------
    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int hit [LOG2N][N];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tb cycle %0d)", nm, act, exp, pcnt);
        end
    endtask

    always @(negedge clk) begin
        int n, s, k, s2, k2, s5, k5, nbad;
        bit e_rd, e_bf, e_wr, ok;
        if (!rst) begin
            if (!mdl_on) begin
                chk("idle_all_zero", |{busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr,
                    bf_en, bf_xp_re, bf_xp_im, bf_xq_re, bf_xq_im, bf_factor_re, bf_factor_im,
                    wr_en, wr_addr_p, wr_addr_q, wr_p_re, wr_p_im, wr_q_re, wr_q_im}, 0);
            end else begin
                n = pcnt - mdl_t0;
                if (n == 0) begin
                    rd_cnt = 0;
                    for (int a = 0; a < LOG2N; a++)
                        for (int b = 0; b < N; b++) hit[a][b] = 0;
                end
                e_rd = issue_at(n, s, k);
                e_bf = issue_at(n - 2, s2, k2);
                e_wr = issue_at(n - 5, s5, k5);
                chk("busy",  busy,  (n >= 1 && n <= LASTWR));
                chk("done",  done,  (n == DONEC));
                chk("rd_en", rd_en, e_rd);
                chk("bf_en", bf_en, e_bf);
                chk("wr_en", wr_en, e_wr);
                if (rd_en === 1'b1 && !$isunknown({rd_addr_p, rd_addr_q}) && e_rd) begin
                    rd_cnt++;
                    hit[s][rd_addr_p]++;
                    hit[s][rd_addr_q]++;
                end
                if (e_rd) begin
                    chk("rd_addr_p", rd_addr_p, plist[s][k]);
                    chk("rd_addr_q", rd_addr_q, qlist[s][k]);
                    chk("tw_addr",   tw_addr,   twlist[s][k]);
                end
                if (e_bf) begin
                    chk("bf_xp_re", bf_xp_re, g_re[s2][plist[s2][k2]]);
                    chk("bf_xp_im", bf_xp_im, g_im[s2][plist[s2][k2]]);
                    chk("bf_xq_re", bf_xq_re, g_re[s2][qlist[s2][k2]]);
                    chk("bf_xq_im", bf_xq_im, g_im[s2][qlist[s2][k2]]);
                    chk("bf_w_re",  bf_factor_re, rom_re[twlist[s2][k2]]);
                    chk("bf_w_im",  bf_factor_im, rom_im[twlist[s2][k2]]);
                end
                if (e_wr) begin
                    chk("wr_addr_p", wr_addr_p, plist[s5][k5]);
                    chk("wr_addr_q", wr_addr_q, qlist[s5][k5]);
                    chk("wr_p_re", wr_p_re, g_re[s5+1][plist[s5][k5]]);
                    chk("wr_p_im", wr_p_im, g_im[s5+1][plist[s5][k5]]);
                    chk("wr_q_re", wr_q_re, g_re[s5+1][qlist[s5][k5]]);
                    chk("wr_q_im", wr_q_im, g_im[s5+1][qlist[s5][k5]]);
                end
                // hand-computed pins
                if (n == 1) begin
                    chk("pin_s0k0_p", rd_addr_p, 0);
                    chk("pin_s0k0_q", rd_addr_q, 1);
                    chk("pin_s0k0_tw", tw_addr, 0);
                end
                if (n == 1 + 133*3 + 9) begin
                    chk("pin_s3k9_p", rd_addr_p, 17);
                    chk("pin_s3k9_q", rd_addr_q, 25);
                    chk("pin_s3k9_tw", tw_addr, 16);
                end
                if (n == 1 + 133*7 + 127) begin
                    chk("pin_s7k127_p", rd_addr_p, 127);
                    chk("pin_s7k127_q", rd_addr_q, 255);
                    chk("pin_s7k127_tw", tw_addr, 127);
                end
                if (n >= 129 && n <= 133) chk("pin_drain_rd_low", rd_en, 0);
                if (n == 133)  chk("pin_s0_last_wr", wr_en, 1);
                if (n == 134)  chk("pin_s1_first_rd", rd_en, 1);
                if (n == 1064) chk("pin_final_wr", wr_en, 1);
                if (n == 1065) begin
                    chk("pin_done_1065", done, 1);
                    chk("pin_busy_1065", busy, 0);
                    chk("total_reads", rd_cnt, 1024);
                    ok = 1'b1;
                    for (int a = 0; a < LOG2N; a++)
                        for (int b = 0; b < N; b++)
                            if (hit[a][b] != 1) ok = 1'b0;
                    chk("addr_once_per_stage", ok, 1);
                    nbad = 0;
                    for (int b = 0; b < N; b++)
                        if (mem_re[b] !== g_re[LOG2N][b] || mem_im[b] !== g_im[LOG2N][b]) nbad++;
                    chk("final_ram_vs_model", nbad, 0);
                    if (imp_run) begin
                        nbad = 0;
                        for (int b = 0; b < N; b++)
                            if (mem_re[b] !== 16'sd100 || mem_im[b] !== 16'sd0) nbad++;
                        chk("impulse_all_100", nbad, 0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_impulse();
        for (int i = 0; i < N; i++) begin
            ini_re[i] = '0;
            ini_im[i] = '0;
        end
        ini_re[0] = 16'sd100;
        compute_gold();
        ld = 1'b1;
        tick();
        ld = 1'b0;
        imp_run = 1'b1;
    endtask

    initial begin
        build_lists();
        // reset with start held high: must be ignored
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) tick();

        // run 1: impulse, with stray starts at 50 and 1065, restart at 1066
        load_impulse();
        start  = 1'b1;
        mdl_t0 = pcnt;
        mdl_on = 1'b1;
        for (int n = 1; n <= 1066; n++) begin
            tick();
            start = (n == 50 || n == 1065 || n == 1066);
            if (n == 1066) begin
                // RAM now holds the run-1 result; it becomes run 2's input
                for (int i = 0; i < N; i++) begin
                    ini_re[i] = g_re[LOG2N][i];
                    ini_im[i] = g_im[LOG2N][i];
                end
                compute_gold();
                imp_run = 1'b0;
                mdl_t0  = pcnt;
            end
        end

        // run 2: constant input exercises the twiddles; reset at cycle 500
        for (int n = 1; n <= 500; n++) begin
            tick();
            start = 1'b0;
            if (n == 500) rst = 1'b1;
        end
        tick();
        rst    = 1'b0;
        mdl_on = 1'b0;
        repeat (6) tick();

        // run 3: impulse again after the aborted run
        load_impulse();
        tick();
        start  = 1'b1;
        mdl_t0 = pcnt;
        mdl_on = 1'b1;
        for (int n = 1; n <= 1070; n++) begin
            tick();
            start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
